// File: rtl/rect_pixel_reader_if.sv
// ----------------------------------------------------------------------------
// rect_pixel_reader_if
// Bundles the signals of rect_pixel_reader so they travel as one port.
// There are two groups of signals:
//   request side (game FSM)  : start, X, Y, target   -> reader
//                              ready, done, hit, hit_count <- reader
//   framebuffer read port    : rd_en, rd_x, rd_y      -> framebuffer
//                              rd_colour              <- framebuffer
// Modports:
//   master : the game FSM plus framebuffer side (the environment)
//   slave  : the reader itself
// ----------------------------------------------------------------------------
interface rect_pixel_reader_if;
    logic       start;
    logic [7:0] X;
    logic [6:0] Y;
    logic [2:0] target;
    logic       ready;
    logic       done;
    logic       hit;
    logic [6:0] hit_count;
    logic       rd_en;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] rd_colour;

    modport master (
        output start, X, Y, target, rd_colour,
        input  ready, done, hit, hit_count, rd_en, rd_x, rd_y
    );

    modport slave (
        input  start, X, Y, target, rd_colour,
        output ready, done, hit, hit_count, rd_en, rd_x, rd_y
    );
endinterface

// File: rtl/rect_pixel_reader.sv
// ----------------------------------------------------------------------------
// rect_pixel_reader
// Scans an XDIM x YDIM square of the 160x120 3-bit framebuffer through its
// read port and counts how many pixels equal a target colour. Used by the
// snake FSM for apple and self-collision detection.
//
// Ports:
//   Clock   : system clock
//   Resetn  : asynchronous active-low reset
//   bus     : rect_pixel_reader_if.slave
//             start/X/Y/target in, ready/done/hit/hit_count out,
//             rd_en/rd_x/rd_y out to framebuffer, rd_colour in
//
// Optional feature macro: RECT_READER_WALL_HIT_EN
//   defined   : every off-screen pixel counts as a match (wall collision),
//               delayed by RD_LAT cycles like a real read.
//   undefined : off-screen pixels never match.
// ----------------------------------------------------------------------------
module rect_pixel_reader #(
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int RD_LAT  = 1
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    rect_pixel_reader_if.slave   bus
);

    localparam int XCW = (XDIM > 1)   ? $clog2(XDIM)   : 1;
    localparam int YCW = (YDIM > 1)   ? $clog2(YDIM)   : 1;
    localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          xl_reg;
    logic [6:0]          yl_reg;
    logic [2:0]          tgt_reg;
    logic [XCW-1:0]      xc_reg;
    logic [YCW-1:0]      yc_reg;
    logic [LCW-1:0]      drain_reg;
    logic [RD_LAT-1:0]   vld_reg, vld_next;
    logic [6:0]          cnt_reg, cnt_next;
    logic                hit_reg;
    logic [7:0]          rdx_hold_reg;
    logic [6:0]          rdy_hold_reg;

    logic                ready_int, done_int, rd_en_int;
    logic                accept, last_x, last_y, on_screen, match;
    logic [8:0]          px;
    logic [7:0]          py;

    // Coordinates are widened before the range check so squares that run
    // past the screen (or past 255/127) are detected rather than wrapped.
    assign px        = {1'b0, xl_reg} + 9'(xc_reg);
    assign py        = {1'b0, yl_reg} + 8'(yc_reg);
    assign on_screen = (px < 9'(XSCREEN)) && (py < 8'(YSCREEN));
    assign last_x    = (xc_reg == XCW'(XDIM - 1));
    assign last_y    = (yc_reg == YCW'(YDIM - 1));
    assign accept    = (state_reg == IDLE) && bus.start;

    // Valid pipeline: stage 0 follows rd_en, the last stage marks the cycle
    // in which rd_colour belongs to a read we issued.
    assign vld_next[0] = rd_en_int;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
        assign vld_next[gi] = vld_reg[gi-1];
    end

`ifdef RECT_READER_WALL_HIT_EN
    logic [RD_LAT-1:0] wall_reg, wall_next;
    assign wall_next[0] = (state_reg == SCAN) && !on_screen;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_wall
        assign wall_next[gi] = wall_reg[gi-1];
    end
    assign match = (vld_reg[RD_LAT-1] && (bus.rd_colour == tgt_reg)) ||
                   wall_reg[RD_LAT-1];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) wall_reg <= '0;
        else         wall_reg <= wall_next;
    end
`else
    assign match = vld_reg[RD_LAT-1] && (bus.rd_colour == tgt_reg);
`endif

    assign cnt_next = (match && (cnt_reg != 7'd127)) ? cnt_reg + 7'd1 : cnt_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = SCAN;
            SCAN:  if (last_x && last_y) state_next = DRAIN;
            DRAIN: if (drain_reg == LCW'(RD_LAT - 1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_int = 1'b0;
        done_int  = 1'b0;
        rd_en_int = 1'b0;
        case (state_reg)
            IDLE:  ready_int = 1'b1;
            SCAN:  rd_en_int = on_screen;
            DONE:  done_int  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            xl_reg       <= '0;
            yl_reg       <= '0;
            tgt_reg      <= '0;
            xc_reg       <= '0;
            yc_reg       <= '0;
            drain_reg    <= '0;
            vld_reg      <= '0;
            cnt_reg      <= '0;
            hit_reg      <= 1'b0;
            rdx_hold_reg <= '0;
            rdy_hold_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            cnt_reg <= accept ? 7'd0 : cnt_next;

            if (accept) begin
                xl_reg  <= bus.X;
                yl_reg  <= bus.Y;
                tgt_reg <= bus.target;
                xc_reg  <= '0;
                yc_reg  <= '0;
                hit_reg <= 1'b0;
            end

            if (state_reg == SCAN) begin
                rdx_hold_reg <= px[7:0];
                rdy_hold_reg <= py[6:0];
                if (last_x) begin
                    xc_reg <= '0;
                    yc_reg <= yc_reg + YCW'(1);
                end else begin
                    xc_reg <= xc_reg + XCW'(1);
                end
            end

            drain_reg <= (state_reg == DRAIN) ? drain_reg + LCW'(1) : '0;

            // The last read result lands on the same edge that enters DONE,
            // so hit is taken from the post-increment count.
            if ((state_reg == DRAIN) && (state_next == DONE))
                hit_reg <= (cnt_next != 7'd0);
        end
    end

    assign bus.ready     = ready_int;
    assign bus.done      = done_int;
    assign bus.rd_en     = rd_en_int;
    assign bus.rd_x      = (state_reg == SCAN) ? px[7:0] : rdx_hold_reg;
    assign bus.rd_y      = (state_reg == SCAN) ? py[6:0] : rdy_hold_reg;
    assign bus.hit       = hit_reg;
    assign bus.hit_count = cnt_reg;

endmodule

// File: tb/tb_rect_pixel_reader.sv
// ----------------------------------------------------------------------------
// tb_rect_pixel_reader
// Two readers share one framebuffer model: instance 0 uses the default
// geometry (10x10, RD_LAT=1), instance 1 uses 12x12 with RD_LAT=3 so the
// saturation and longer-latency behaviour are exercised in one build.
// Requests push their expected result (computed directly from the framebuffer
// contents) into a per-instance scoreboard; a monitor checks every read
// address and every done pulse against it.
// ----------------------------------------------------------------------------
module tb_rect_pixel_reader;

    typedef struct {
        int cnt;
        int nrd;
        int lat;
    } exp_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b1;
    always #5 Clock = ~Clock;

    logic [2:0] fb [160*120];

    logic       start_d [2];
    logic [7:0] x_d     [2];
    logic [6:0] y_d     [2];
    logic [2:0] t_d     [2];
    logic       ready_w [2];
    logic       done_w  [2];
    logic       hit_w   [2];
    logic       rden_w  [2];
    logic [6:0] hc_w    [2];
    logic [7:0] rx_w    [2];
    logic [6:0] ry_w    [2];

    exp_t exp_q  [2][$];
    int   addr_q [2][$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int xd(input int inst);
        return (inst == 1) ? 12 : 10;
    endfunction
    function automatic int lt(input int inst);
        return (inst == 1) ? 3 : 1;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int XD = (gi == 1) ? 12 : 10;
        localparam int LT = (gi == 1) ? 3 : 1;

        rect_pixel_reader_if bus ();

        rect_pixel_reader #(.XDIM(XD), .YDIM(XD), .XSCREEN(160), .YSCREEN(120), .RD_LAT(LT)) dut (
            .Clock  (Clock),
            .Resetn (Resetn),
            .bus    (bus)
        );

        // Framebuffer read port: data appears LT cycles after rd_en; between
        // reads the bus carries random junk that must never be counted.
        logic [2:0] pipe [LT];
        always @(posedge Clock) begin
            if (bus.rd_en && bus.rd_x < 8'd160 && bus.rd_y < 7'd120)
                pipe[0] <= fb[int'(bus.rd_y) * 160 + int'(bus.rd_x)];
            else
                pipe[0] <= 3'($urandom);
            for (int k = 1; k < LT; k++) pipe[k] <= pipe[k-1];
        end

        assign bus.rd_colour = pipe[LT-1];
        assign bus.start     = start_d[gi];
        assign bus.X         = x_d[gi];
        assign bus.Y         = y_d[gi];
        assign bus.target    = t_d[gi];
        assign ready_w[gi]   = bus.ready;
        assign done_w[gi]    = bus.done;
        assign hit_w[gi]     = bus.hit;
        assign rden_w[gi]    = bus.rd_en;
        assign hc_w[gi]      = bus.hit_count;
        assign rx_w[gi]      = bus.rd_x;
        assign ry_w[gi]      = bus.rd_y;
    end

    task automatic chk(input string name, input int inst, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL inst%0d %s: got %0d, expected %0d", inst, name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit rst_seen [2];
    bit post     [2];
    int post_cnt [2];
    int acc_cyc  [2];
    int nrd      [2];
    int age      [2];

    always @(negedge Clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!Resetn) begin
                if (!rst_seen[i]) begin
                    chk("rst_ready", i, int'(ready_w[i]), 1);
                    chk("rst_done",  i, int'(done_w[i]), 0);
                    chk("rst_rd_en", i, int'(rden_w[i]), 0);
                    chk("rst_hit",   i, int'(hit_w[i]), 0);
                    chk("rst_count", i, int'(hc_w[i]), 0);
                    chk("rst_rd_x",  i, int'(rx_w[i]), 0);
                    chk("rst_rd_y",  i, int'(ry_w[i]), 0);
                    rst_seen[i] = 1'b1;
                end
                exp_q[i].delete();
                addr_q[i].delete();
                post[i] = 1'b0;
                age[i]  = 0;
            end else begin
                rst_seen[i] = 1'b0;
                if (post[i]) begin
                    chk("post_ready", i, int'(ready_w[i]), 1);
                    chk("post_count_held", i, int'(hc_w[i]), post_cnt[i]);
                    post[i] = 1'b0;
                end
                if (start_d[i] && ready_w[i]) begin
                    acc_cyc[i] = cyc + 1;
                    nrd[i] = 0;
                end
                if (rden_w[i]) begin
                    nrd[i]++;
                    if (addr_q[i].size() == 0) begin
                        chk("unexpected_read", i, 1, 0);
                    end else begin
                        int a;
                        a = addr_q[i].pop_front();
                        chk("rd_addr", i, int'(ry_w[i]) * 256 + int'(rx_w[i]), a);
                    end
                end
                if (done_w[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_done", i, 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        chk("latency",   i, cyc - acc_cyc[i], e.lat);
                        chk("hit_count", i, int'(hc_w[i]), e.cnt);
                        chk("hit",       i, int'(hit_w[i]), (e.cnt != 0) ? 1 : 0);
                        chk("num_reads", i, nrd[i], e.nrd);
                        chk("done_ready", i, int'(ready_w[i]), 0);
                        $display("[TB] inst%0d done: hit=%0d hit_count=%0d (exp %0d) reads=%0d latency=%0d",
                                 i, hit_w[i], hc_w[i], e.cnt, nrd[i], cyc - acc_cyc[i]);
                        post[i]     = 1'b1;
                        post_cnt[i] = e.cnt;
                    end
                    age[i] = 0;
                end else if (exp_q[i].size() != 0) begin
                    age[i]++;
                    if (age[i] > 600) begin
                        chk("done_timeout", i, 0, 1);
                        void'(exp_q[i].pop_front());
                        age[i] = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int inst, input int x, input int y, input int t);
        exp_t e;
        int   cnt;
        int   reads;
        int   wall;
        int   k;
`ifdef RECT_READER_WALL_HIT_EN
        wall = 1;
`else
        wall = 0;
`endif
        cnt = 0;
        reads = 0;
        for (int yc = 0; yc < xd(inst); yc++) begin
            for (int xc = 0; xc < xd(inst); xc++) begin
                int px, py;
                px = x + xc;
                py = y + yc;
                if (px < 160 && py < 120) begin
                    addr_q[inst].push_back((py % 128) * 256 + (px % 256));
                    reads++;
                    if (int'(fb[py * 160 + px]) == t) cnt++;
                end else if (wall != 0) begin
                    cnt++;
                end
            end
        end
        e.cnt = (cnt > 127) ? 127 : cnt;
        e.nrd = reads;
        e.lat = xd(inst) * xd(inst) + lt(inst);
        exp_q[inst].push_back(e);
        $display("[TB] inst%0d request X=%0d Y=%0d target=%0d expect count=%0d reads=%0d",
                 inst, x, y, t, e.cnt, reads);
        @(posedge Clock); #2;
        k = 0;
        while (!ready_w[inst] && k < 800) begin
            @(posedge Clock); #2;
            k++;
        end
        start_d[inst] = 1'b1;
        x_d[inst] = 8'(x);
        y_d[inst] = 7'(y);
        t_d[inst] = 3'(t);
        @(posedge Clock); #2;
        start_d[inst] = 1'b0;
        // Post-acceptance changes must not affect the running scan.
        x_d[inst] = 8'($urandom);
        y_d[inst] = 7'($urandom);
        t_d[inst] = 3'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && k < 3000) begin
            @(posedge Clock);
            k++;
        end
        repeat (3) @(posedge Clock);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_d[i] = 1'b0;
            x_d[i] = '0;
            y_d[i] = '0;
            t_d[i] = '0;
        end
        for (int i = 0; i < 160 * 120; i++) fb[i] = 3'd0;

        #1 Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        #2 Resetn = 1'b1;

        // All-zero framebuffer, target 100: no hits.
        issue(0, 30, 30, 4);
        wait_idle();

        // Two corner pixels of the square set to 100.
        fb[30 * 160 + 30] = 3'd4;
        fb[39 * 160 + 39] = 3'd4;
        issue(0, 30, 30, 4);
        wait_idle();
        issue(1, 30, 30, 4);
        wait_idle();

        // Square hanging off the bottom-right corner.
        issue(0, 155, 115, 0);
        wait_idle();

        // Start during SCAN is ignored; a new request the cycle after done
        // is accepted.
        issue(0, 30, 30, 4);
        repeat (48) @(posedge Clock);
        #2;
        start_d[0] = 1'b1;
        x_d[0] = 8'd100;
        @(posedge Clock); #2;
        start_d[0] = 1'b0;
        issue(0, 0, 0, 0);
        wait_idle();

        // Asynchronous reset in the middle of a scan, then a clean request.
        issue(0, 0, 0, 0);
        repeat (39) @(posedge Clock);
        #2 Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        #2 Resetn = 1'b1;
        issue(0, 0, 0, 0);
        wait_idle();

        // 12x12 square fully coloured 010: saturates at 127.
        for (int yy = 50; yy < 62; yy++)
            for (int xx = 50; xx < 62; xx++)
                fb[yy * 160 + xx] = 3'd2;
        issue(1, 50, 50, 2);
        issue(0, 50, 50, 2);
        wait_idle();

        // Randomised rounds on both instances with a two-colour framebuffer.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 160 * 120; i++) fb[i] = 3'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) begin
                issue(j % 2, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 1));
                issue((j + 1) % 2, $urandom_range(0, 165), $urandom_range(0, 125), $urandom_range(0, 1));
            end
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
